// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for a 5-stage RISC-V pipeline: EX bypass selects,
// load-use stall sequencing, cache-miss freeze and saturating event counters.
module fwd_hazard_ctrl #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned AW       = 5,
    parameter int unsigned LU_STALL = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_SRC*AW-1:0]   ID_rs_i,
    input  logic [NUM_SRC-1:0]      ID_rs_used_i,
    input  logic [NUM_SRC*AW-1:0]   EX_rs_i,
    input  logic                    EX_MemRead_i,
    input  logic [AW-1:0]           EX_rd_i,
    input  logic                    MEM_RegWrite_i,
    input  logic [AW-1:0]           MEM_rd_i,
    input  logic                    WB_RegWrite_i,
    input  logic [AW-1:0]           WB_rd_i,
    input  logic                    mem_stall_i,
    input  logic                    cnt_clr_i,
    output logic [NUM_SRC*2-1:0]    forward_o,
    output logic                    stall_o,
    output logic                    flush_ex_o,
    output logic                    freeze_o,
    output logic [CNT_W-1:0]        fwd_cnt_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    localparam int unsigned RW = 4;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_LU_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [RW-1:0]    remain_q, remain_d;
    logic [CNT_W-1:0] fwd_cnt_q, stall_cnt_q;
    logic [NUM_SRC*2-1:0] fwd;
    logic             lu_hit;
    logic             stall_c, flush_c, freeze_c;

    // Bypass selects: MEM result has priority over WB, x0 is never forwarded.
    always_comb begin
        fwd = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (MEM_RegWrite_i && (MEM_rd_i != '0) && (MEM_rd_i == EX_rs_i[k*AW +: AW]))
                fwd[k*2 +: 2] = 2'b10;
            else if (WB_RegWrite_i && (WB_rd_i != '0) && (WB_rd_i == EX_rs_i[k*AW +: AW]))
                fwd[k*2 +: 2] = 2'b01;
        end
    end

    always_comb begin
        lu_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ID_rs_used_i[k] && (ID_rs_i[k*AW +: AW] == EX_rd_i))
                lu_hit = 1'b1;
        end
        lu_hit = lu_hit && EX_MemRead_i && (EX_rd_i != '0);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Next state and stall controls; a cache freeze overrides any load-use action.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        freeze_c = 1'b0;
        if (mem_stall_i) begin
            freeze_c = 1'b1;
            stall_c  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lu_hit) begin
                        stall_c = 1'b1;
                        flush_c = 1'b1;
                        if (LU_STALL > 1) begin
                            state_d  = ST_LU_WAIT;
                            remain_d = RW'(LU_STALL - 1);
                        end
                    end
                end
                ST_LU_WAIT: begin
                    stall_c  = 1'b1;
                    flush_c  = 1'b1;
                    remain_d = remain_q - RW'(1);
                    if (remain_q == RW'(1))
                        state_d = ST_IDLE;
                end
                default: begin
                    state_d  = ST_IDLE;
                    remain_d = '0;
                end
            endcase
        end
    end

    // Saturating event counters; clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (!mem_stall_i && (|fwd) && (fwd_cnt_q != {CNT_W{1'b1}}))
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
            if (flush_c && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Control outputs drop immediately on reset, without waiting for a clock edge.
    assign forward_o   = fwd;
    assign stall_o     = stall_c  & rst_i;
    assign flush_ex_o  = flush_c  & rst_i;
    assign freeze_o    = freeze_c & rst_i;
    assign fwd_cnt_o   = fwd_cnt_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: vector table on the default build, plus sequences on
// LU_STALL=3 and CNT_W=4 builds for stall length, freeze, saturation and reset.
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs0, id_rs1, ex_rs0, ex_rs1, ex_rd, mem_rd, wb_rd;
    logic [1:0]  id_used;
    logic        ex_ld, mem_rw, wb_rw, mem_stall, cnt_clr;

    logic [3:0]  fwd_a, fwd_b, fwd_c;
    logic        stall_a, flush_a, frz_a;
    logic        stall_b, flush_b, frz_b;
    logic        stall_c, flush_c, frz_c;
    logic [15:0] fcnt_a, scnt_a, fcnt_b, scnt_b;
    logic [3:0]  fcnt_c, scnt_c;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl u_a (
        .clk_i(clk), .rst_i(rst_n), .ID_rs_i({id_rs1, id_rs0}), .ID_rs_used_i(id_used),
        .EX_rs_i({ex_rs1, ex_rs0}), .EX_MemRead_i(ex_ld), .EX_rd_i(ex_rd),
        .MEM_RegWrite_i(mem_rw), .MEM_rd_i(mem_rd), .WB_RegWrite_i(wb_rw), .WB_rd_i(wb_rd),
        .mem_stall_i(mem_stall), .cnt_clr_i(cnt_clr), .forward_o(fwd_a), .stall_o(stall_a),
        .flush_ex_o(flush_a), .freeze_o(frz_a), .fwd_cnt_o(fcnt_a), .stall_cnt_o(scnt_a));

    fwd_hazard_ctrl #(.LU_STALL(3)) u_b (
        .clk_i(clk), .rst_i(rst_n), .ID_rs_i({id_rs1, id_rs0}), .ID_rs_used_i(id_used),
        .EX_rs_i({ex_rs1, ex_rs0}), .EX_MemRead_i(ex_ld), .EX_rd_i(ex_rd),
        .MEM_RegWrite_i(mem_rw), .MEM_rd_i(mem_rd), .WB_RegWrite_i(wb_rw), .WB_rd_i(wb_rd),
        .mem_stall_i(mem_stall), .cnt_clr_i(cnt_clr), .forward_o(fwd_b), .stall_o(stall_b),
        .flush_ex_o(flush_b), .freeze_o(frz_b), .fwd_cnt_o(fcnt_b), .stall_cnt_o(scnt_b));

    fwd_hazard_ctrl #(.CNT_W(4)) u_c (
        .clk_i(clk), .rst_i(rst_n), .ID_rs_i({id_rs1, id_rs0}), .ID_rs_used_i(id_used),
        .EX_rs_i({ex_rs1, ex_rs0}), .EX_MemRead_i(ex_ld), .EX_rd_i(ex_rd),
        .MEM_RegWrite_i(mem_rw), .MEM_rd_i(mem_rd), .WB_RegWrite_i(wb_rw), .WB_rd_i(wb_rd),
        .mem_stall_i(mem_stall), .cnt_clr_i(cnt_clr), .forward_o(fwd_c), .stall_o(stall_c),
        .flush_ex_o(flush_c), .freeze_o(frz_c), .fwd_cnt_o(fcnt_c), .stall_cnt_o(scnt_c));

    typedef struct {
        logic [4:0] ex_rs0, ex_rs1;
        logic       mem_rw;
        logic [4:0] mem_rd;
        logic       wb_rw;
        logic [4:0] wb_rd;
        logic       ld;
        logic [4:0] ex_rd, id_rs0, id_rs1;
        logic [1:0] used;
        logic [3:0] fwd;
        logic       stl;
    } vec_t;

    vec_t vt[11];

    function automatic vec_t mk(input logic [4:0] e0, e1, input logic mw, input logic [4:0] md,
                                input logic ww, input logic [4:0] wd, input logic ld,
                                input logic [4:0] erd, i0, i1, input logic [1:0] u,
                                input logic [3:0] f, input logic s);
        vec_t v;
        v.ex_rs0 = e0; v.ex_rs1 = e1; v.mem_rw = mw; v.mem_rd = md; v.wb_rw = ww; v.wb_rd = wd;
        v.ld = ld; v.ex_rd = erd; v.id_rs0 = i0; v.id_rs1 = i1; v.used = u; v.fwd = f; v.stl = s;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs0 = '0; id_rs1 = '0; id_used = '0; ex_rs0 = '0; ex_rs1 = '0; ex_rd = '0;
        ex_ld = 1'b0; mem_rw = 1'b0; mem_rd = '0; wb_rw = 1'b0; wb_rd = '0;
        mem_stall = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Load of x3 in EX, ID reading x3 on port 1.
    task automatic lu_hit_inputs();
        ex_ld = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_used = 2'b10;
    endtask

    initial begin
        int n_st, n_fl, n_fz;

        vt[0]  = mk(5, 0, 1, 5, 1, 5, 0, 0, 0, 0, 2'b00, 4'b0010, 0);
        vt[1]  = mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);
        vt[2]  = mk(7, 7, 0, 7, 1, 7, 0, 0, 0, 0, 2'b00, 4'b0101, 0);
        vt[3]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 0);
        vt[4]  = mk(4, 9, 1, 9, 1, 4, 0, 0, 0, 0, 2'b00, 4'b1001, 0);
        vt[5]  = mk(4, 9, 0, 9, 0, 4, 0, 0, 0, 0, 2'b00, 4'b0000, 0);
        vt[6]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 2, 3, 2'b10, 4'b0000, 1);
        vt[7]  = mk(0, 0, 0, 0, 0, 0, 1, 3, 2, 3, 2'b01, 4'b0000, 0);
        vt[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b11, 4'b0000, 0);
        vt[9]  = mk(0, 0, 0, 0, 0, 0, 0, 3, 3, 3, 2'b11, 4'b0000, 0);
        vt[10] = mk(6, 6, 1, 6, 0, 0, 1, 3, 3, 8, 2'b01, 4'b1010, 1);

        rst_n = 1'b1;
        idle_inputs();
        do_reset();

        @(negedge clk); #2;
        chk("reset stall", 32'(stall_a), 32'd0);
        chk("reset flush", 32'(flush_a), 32'd0);
        chk("reset freeze", 32'(frz_a), 32'd0);
        chk("reset fwd_cnt", 32'(fcnt_a), 32'd0);
        chk("reset stall_cnt", 32'(scnt_a), 32'd0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ex_rs0 = vt[i].ex_rs0; ex_rs1 = vt[i].ex_rs1; mem_rw = vt[i].mem_rw;
            mem_rd = vt[i].mem_rd; wb_rw = vt[i].wb_rw; wb_rd = vt[i].wb_rd; ex_ld = vt[i].ld;
            ex_rd = vt[i].ex_rd; id_rs0 = vt[i].id_rs0; id_rs1 = vt[i].id_rs1; id_used = vt[i].used;
            #2;
            chk($sformatf("v%0d forward", i), 32'(fwd_a), 32'(vt[i].fwd));
            chk($sformatf("v%0d stall", i), 32'(stall_a), 32'(vt[i].stl));
            chk($sformatf("v%0d flush", i), 32'(flush_a), 32'(vt[i].stl));
            chk($sformatf("v%0d freeze", i), 32'(frz_a), 32'd0);
        end

        // LU_STALL=1: one stall cycle counted.
        do_reset();
        @(negedge clk); lu_hit_inputs(); #2;
        chk("lu1 stall", 32'(stall_a), 32'd1);
        @(negedge clk); ex_ld = 1'b0; #2;
        chk("lu1 stall drop", 32'(stall_a), 32'd0);
        chk("lu1 stall_cnt", 32'(scnt_a), 32'd1);

        // LU_STALL=3: three stall cycles.
        do_reset();
        n_st = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) lu_hit_inputs(); else ex_ld = 1'b0;
            #2;
            if (stall_b) n_st++;
        end
        chk("lu3 stall cycles", 32'(n_st), 32'd3);
        chk("lu3 stall_cnt", 32'(scnt_b), 32'd3);

        // LU_STALL=3 with a 2-cycle cache freeze inside the sequence.
        do_reset();
        n_st = 0; n_fl = 0; n_fz = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) lu_hit_inputs(); else ex_ld = 1'b0;
            mem_stall = (i == 1 || i == 2);
            #2;
            if (stall_b) n_st++;
            if (flush_b) n_fl++;
            if (frz_b) n_fz++;
        end
        chk("lu3 frz stall cycles", 32'(n_st), 32'd5);
        chk("lu3 frz flush cycles", 32'(n_fl), 32'd3);
        chk("lu3 frz freeze cycles", 32'(n_fz), 32'd2);
        chk("lu3 frz stall_cnt", 32'(scnt_b), 32'd3);

        // CNT_W=4: saturate, clear, hold during freeze.
        do_reset();
        @(negedge clk); mem_rw = 1'b1; mem_rd = 5'd5; ex_rs0 = 5'd5;
        repeat (20) @(negedge clk);
        #2;
        chk("sat fwd_cnt", 32'(fcnt_c), 32'd15);
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0; mem_stall = 1'b1; #2;
        chk("clr fwd_cnt", 32'(fcnt_c), 32'd0);
        chk("frz freeze_o", 32'(frz_c), 32'd1);
        chk("frz stall_o", 32'(stall_c), 32'd1);
        chk("frz flush_o", 32'(flush_c), 32'd0);
        chk("frz forward", 32'(fwd_c), 32'b0010);
        repeat (3) @(negedge clk);
        #2;
        chk("frz fwd_cnt hold", 32'(fcnt_c), 32'd0);
        mem_stall = 1'b0;
        @(negedge clk); #2;
        chk("unfrz fwd_cnt", 32'(fcnt_c), 32'd1);

        // Async reset in the middle of LU_WAIT.
        do_reset();
        @(negedge clk); lu_hit_inputs();
        @(negedge clk); ex_ld = 1'b0; #2;
        chk("wait stall", 32'(stall_b), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst stall", 32'(stall_b), 32'd0);
        chk("async rst flush", 32'(flush_b), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #2;
        chk("post rst stall", 32'(stall_b), 32'd0);
        chk("post rst stall_cnt", 32'(scnt_b), 32'd0);
        chk("post rst fwd_cnt", 32'(fcnt_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
